// File: rtl/k_and_s_datapath_if.sv
// Shared decode type and the control-unit/datapath bus of the K-and-S machine.
// Optional K_AND_S_ILLEGAL_OP_EN adds the sticky illegal_op status line.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
    } decoded_instruction_type;
endpackage

interface k_and_s_datapath_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic                                 branch;
    logic                                 pc_enable;
    logic                                 ir_enable;
    logic                                 write_reg_enable;
    logic                                 addr_sel;
    logic                                 c_sel;
    logic [1:0]                           operation;
    logic                                 flags_reg_enable;
    k_and_s_pkg::decoded_instruction_type decoded_instruction;
    logic                                 zero_op;
    logic                                 neg_op;
    logic                                 unsigned_overflow;
    logic                                 signed_overflow;
    logic [ADDR_W-1:0]                    ram_addr;
    logic [DATA_W-1:0]                    data_out;
    logic [DATA_W-1:0]                    data_in;
`ifdef K_AND_S_ILLEGAL_OP_EN
    logic                                 illegal_op;
`endif

    modport master (
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, operation,
               flags_reg_enable, data_in,
`ifdef K_AND_S_ILLEGAL_OP_EN
        input  illegal_op,
`endif
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
               ram_addr, data_out
    );

    modport slave (
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, operation,
               flags_reg_enable, data_in,
`ifdef K_AND_S_ILLEGAL_OP_EN
        output illegal_op,
`endif
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
               ram_addr, data_out
    );
endinterface

// File: rtl/k_and_s_datapath.sv
// K-and-S datapath: PC, IR, 4x16 register file, ALU and flags register.
// Define K_AND_S_ILLEGAL_OP_EN to flag fetches of unlisted opcodes.
module k_and_s_datapath
    import k_and_s_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 4
) (
    input logic               clk,
    input logic               rst_n,
    k_and_s_datapath_if.slave bus
);
    localparam int unsigned RegW = $clog2(NREGS);

    function automatic decoded_instruction_type decode(input logic [7:0] op);
        case (op)
            8'h81:   decode = I_LOAD;
            8'h82:   decode = I_STORE;
            8'h91:   decode = I_MOVE;
            8'hA1:   decode = I_ADD;
            8'hA2:   decode = I_SUB;
            8'hA3:   decode = I_AND;
            8'hA4:   decode = I_OR;
            8'h01:   decode = I_BRANCH;
            8'h02:   decode = I_BZERO;
            8'h03:   decode = I_BNEG;
            8'h04:   decode = I_BOV;
            8'h05:   decode = I_BNOV;
            8'h0A:   decode = I_BNNEG;
            8'h0B:   decode = I_BNZERO;
            8'hFF:   decode = I_HALT;
            default: decode = I_NOP;
        endcase
    endfunction

    logic [ADDR_W-1:0]       pc_q, pc_d;
    logic [DATA_W-1:0]       ir_q;
    logic [DATA_W-1:0]       regs_q [NREGS];
    logic                    zero_q, neg_q, uov_q, sov_q;
    decoded_instruction_type instr;
    logic [RegW-1:0]         sel_a, sel_b, sel_dest, sel_mem;
    logic [DATA_W-1:0]       op_a, op_b, alu_res, reg_wdata;
    logic [DATA_W:0]         sum;
    logic                    alu_uov, alu_sov;
    logic                    unused_ir;

    assign unused_ir = ir_q[7];

    always_comb begin
        instr    = decode(ir_q[15:8]);
        sel_mem  = ir_q[5 +: RegW];
        sel_a    = ir_q[2 +: RegW];
        sel_b    = ir_q[0 +: RegW];
        sel_dest = ir_q[4 +: RegW];
        // MOVE feeds src to both operands so AND/OR passes it through unchanged
        if (instr == I_MOVE) begin
            sel_a    = ir_q[0 +: RegW];
            sel_dest = ir_q[2 +: RegW];
        end
        if (instr == I_LOAD) sel_dest = sel_mem;
    end

    always_comb begin
        op_a    = regs_q[sel_a];
        op_b    = regs_q[sel_b];
        sum     = {1'b0, op_a} + {1'b0, op_b};
        alu_res = '0;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        unique case (bus.operation)
            2'b00: begin
                alu_res = sum[DATA_W-1:0];
                alu_uov = sum[DATA_W];
                alu_sov = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            2'b01: begin
                alu_res = op_a - op_b;
                alu_uov = op_a < op_b;
                alu_sov = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            2'b10: alu_res = op_a & op_b;
            2'b11: alu_res = op_a | op_b;
        endcase
        reg_wdata = bus.c_sel ? bus.data_in : alu_res;
        pc_d      = bus.branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            ir_q   <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uov_q  <= 1'b0;
            sov_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (bus.pc_enable)        pc_q             <= pc_d;
            if (bus.ir_enable)        ir_q             <= bus.data_in;
            if (bus.write_reg_enable) regs_q[sel_dest] <= reg_wdata;
            if (bus.flags_reg_enable) begin
                zero_q <= (alu_res == '0);
                neg_q  <= alu_res[DATA_W-1];
                uov_q  <= alu_uov;
                sov_q  <= alu_sov;
            end
        end
    end

`ifdef K_AND_S_ILLEGAL_OP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (bus.ir_enable && decode(bus.data_in[15:8]) == I_NOP &&
                     bus.data_in[15:8] != 8'h00) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_q;
`endif

    assign bus.decoded_instruction = instr;
    assign bus.ram_addr            = bus.addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign bus.data_out            = regs_q[sel_mem];
    assign bus.zero_op             = zero_q;
    assign bus.neg_op              = neg_q;
    assign bus.unsigned_overflow   = uov_q;
    assign bus.signed_overflow     = sov_q;
endmodule

// File: tb/tb_k_and_s_datapath.sv
// Directed bench for k_and_s_datapath; illegal_op checks build with K_AND_S_ILLEGAL_OP_EN.
module tb_k_and_s_datapath;
    import k_and_s_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [15:0] rv;

    k_and_s_datapath_if bus ();

    k_and_s_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.branch           = 1'b0;
        bus.pc_enable        = 1'b0;
        bus.ir_enable        = 1'b0;
        bus.write_reg_enable = 1'b0;
        bus.c_sel            = 1'b0;
        bus.flags_reg_enable = 1'b0;
    endtask

    task automatic load_ir(input logic [15:0] w);
        bus.data_in   = w;
        bus.ir_enable = 1'b1;
        tick();
        bus.ir_enable = 1'b0;
    endtask

    task automatic set_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir(16'h8100 | {9'd0, r, 5'd0});
        bus.data_in          = v;
        bus.c_sel            = 1'b1;
        bus.write_reg_enable = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [15:0] v);
        load_ir(16'h8200 | {9'd0, r, 5'd0});
        v = bus.data_out;
    endtask

    task automatic alu(input logic [15:0] ir, input logic [1:0] op);
        load_ir(ir);
        bus.operation        = op;
        bus.write_reg_enable = 1'b1;
        bus.flags_reg_enable = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.addr_sel  = 1'b0;
        bus.operation = 2'b00;
        bus.data_in   = '0;
        idle();
        #1;
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_decode", bus.decoded_instruction, I_NOP);
        chk("rst_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow,
                          bus.signed_overflow}, 0);
        tick();
        rst_n = 1'b1;

        // LOAD fetch, address mux, register write from data_in
        load_ir(16'h8143);
        chk("load_decode", bus.decoded_instruction, I_LOAD);
        chk("load_addr_pc", bus.ram_addr, 0);
        bus.addr_sel = 1'b1;
        #1;
        chk("load_addr_ir", bus.ram_addr, 3);
        bus.data_in          = 16'h1234;
        bus.c_sel            = 1'b1;
        bus.write_reg_enable = 1'b1;
        tick();
        idle();
        chk("load_r2", bus.data_out, 16'h1234);
        bus.addr_sel = 1'b0;

        // ADD signed overflow
        set_reg(0, 16'h7FFF);
        set_reg(1, 16'h0001);
        alu(16'hA121, 2'b00);
        chk("add_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow,
                          bus.signed_overflow}, 4'b0101);
        read_reg(2, rv);
        chk("add_r2", rv, 16'h8000);

        // SUB to zero, then borrow
        set_reg(0, 16'h0005);
        set_reg(1, 16'h0005);
        alu(16'hA231, 2'b01);
        chk("sub0_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow,
                           bus.signed_overflow}, 4'b1000);
        read_reg(3, rv);
        chk("sub0_r3", rv, 16'h0000);
        set_reg(1, 16'h0006);
        alu(16'hA231, 2'b01);
        chk("subb_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow,
                           bus.signed_overflow}, 4'b0110);
        read_reg(3, rv);
        chk("subb_r3", rv, 16'hFFFF);

        // MOVE r1->r3 via AND clears overflow flags; OR on ALU fields
        alu(16'h910D, 2'b10);
        chk("move_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow,
                           bus.signed_overflow}, 4'b0000);
        read_reg(3, rv);
        chk("move_r3", rv, 16'h0006);
        alu(16'hA401, 2'b11);
        read_reg(0, rv);
        chk("or_r0", rv, 16'h0007);

        load_ir(16'h0A00);
        chk("dec_bnneg", bus.decoded_instruction, I_BNNEG);
        load_ir(16'hFF00);
        chk("dec_halt", bus.decoded_instruction, I_HALT);
        load_ir(16'h0500);
        chk("dec_bnov", bus.decoded_instruction, I_BNOV);
        load_ir(16'h7700);
        chk("dec_unlisted", bus.decoded_instruction, I_NOP);

        // PC branch, wrap and hold
        load_ir(16'h011F);
        chk("dec_branch", bus.decoded_instruction, I_BRANCH);
        bus.branch    = 1'b1;
        bus.pc_enable = 1'b1;
        tick();
        chk("pc_31", bus.ram_addr, 31);
        bus.branch = 1'b0;
        tick();
        chk("pc_wrap", bus.ram_addr, 0);
        idle();
        load_ir(16'h0114);
        bus.branch    = 1'b1;
        bus.pc_enable = 1'b1;
        tick();
        chk("pc_branch", bus.ram_addr, 5'h14);
        bus.pc_enable = 1'b0;
        tick();
        chk("pc_hold", bus.ram_addr, 5'h14);
        bus.branch    = 1'b0;
        bus.pc_enable = 1'b1;
        tick();
        idle();
        chk("pc_inc", bus.ram_addr, 5'h15);

        // All strobes in one cycle: write uses the pre-edge IR
        set_reg(0, 16'h0002);
        set_reg(1, 16'h0003);
        load_ir(16'hA121);
        bus.data_in          = 16'h8240;
        bus.ir_enable        = 1'b1;
        bus.write_reg_enable = 1'b1;
        bus.pc_enable        = 1'b1;
        bus.operation        = 2'b00;
        tick();
        idle();
        chk("sim_decode", bus.decoded_instruction, I_STORE);
        chk("sim_r2", bus.data_out, 16'h0005);
        chk("sim_pc", bus.ram_addr, 5'h16);

        // ADD carry-out to zero
        set_reg(0, 16'hFFFF);
        set_reg(1, 16'h0001);
        alu(16'hA121, 2'b00);
        chk("carry_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow,
                            bus.signed_overflow}, 4'b1010);

        // STORE, then asynchronous reset mid-cycle
        set_reg(3, 16'hBEEF);
        load_ir(16'h8260);
        bus.addr_sel = 1'b1;
        #1;
        chk("st_decode", bus.decoded_instruction, I_STORE);
        chk("st_addr", bus.ram_addr, 0);
        chk("st_data", bus.data_out, 16'hBEEF);
        bus.addr_sel = 1'b0;
        #1;
        chk("st_pc", bus.ram_addr, 5'h16);
        rst_n = 1'b0;
        #1;
        chk("arst_pc", bus.ram_addr, 0);
        chk("arst_decode", bus.decoded_instruction, I_NOP);
        chk("arst_data", bus.data_out, 0);
        chk("arst_flags", {bus.zero_op, bus.neg_op, bus.unsigned_overflow,
                           bus.signed_overflow}, 0);
        tick();
        rst_n = 1'b1;
        read_reg(3, rv);
        chk("arst_r3", rv, 0);
        read_reg(0, rv);
        chk("arst_r0", rv, 0);

`ifdef K_AND_S_ILLEGAL_OP_EN
        chk("ill_rst", bus.illegal_op, 0);
        load_ir(16'h7700);
        chk("ill_decode", bus.decoded_instruction, I_NOP);
        chk("ill_set", bus.illegal_op, 1);
        load_ir(16'h8143);
        chk("ill_valid_decode", bus.decoded_instruction, I_LOAD);
        chk("ill_sticky", bus.illegal_op, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/k_and_s_datapath.md
Name: k_and_s_datapath

Overview:
- Datapath paired with the K-and-S control unit: receives its control strobes and returns the decoded instruction and status flags.
- Holds the PC, the IR, a 4x16 register file, the ALU and the flags register.
- Drives the address and write-data buses of the unified 32x16 program/data RAM and takes RAM read data back.
- The control unit drives RAM write-enable straight to the RAM; that signal does not pass through this block.

Parameters:
- DATA_W, 16, data, IR and register width.
- ADDR_W, 5, RAM address and PC width.
- NREGS, 4, register file depth (2-bit register fields).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch  in  1  PC loads branch target instead of incrementing.
- pc_enable  in  1  PC update strobe.
- ir_enable  in  1  IR load strobe.
- write_reg_enable  in  1  register file write strobe.
- addr_sel  in  1  0: ram_addr=PC, 1: ram_addr=IR[4:0].
- c_sel  in  1  register write source, 0: ALU result, 1: data_in.
- operation  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
- flags_reg_enable  in  1  flags register load strobe.
- decoded_instruction  out  decoded_instruction_type  combinational decode of IR.
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.
- ram_addr  out  ADDR_W  RAM address.
- data_out  out  DATA_W  RAM write data.
- data_in  in  DATA_W  RAM read data.

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: PC=0, IR=0 (decodes I_NOP), all registers=0, all flags=0.
  - The outputs are therefore ram_addr=0, data_out=0 and decoded_instruction=I_NOP.
  - Reset mid-instruction clears everything immediately, regardless of the strobes.
- Decode is on IR[15:8]:
  - 0x00 NOP; 0x81 LOAD; 0x82 STORE; 0x91 MOVE.
  - 0xA1 ADD; 0xA2 SUB; 0xA3 AND; 0xA4 OR.
  - 0x01 BRANCH; 0x02 BZERO; 0x03 BNEG; 0x04 BOV; 0x05 BNOV; 0x0A BNNEG; 0x0B BNZERO.
  - 0xFF HALT.
  - Any other opcode decodes to I_NOP.
- Field layout:
  - Memory address is IR[4:0].
  - LOAD/STORE register is IR[6:5].
  - ALU ops: dest IR[5:4], A IR[3:2], B IR[1:0].
  - MOVE: dest IR[3:2], src IR[1:0]. The src field drives both ALU operands, so AND or OR yields src unchanged.
- PC: on pc_enable, loads IR[4:0] if branch=1, else PC+1 modulo 32 (31 wraps to 0). branch without pc_enable has no effect.
- IR: loads data_in on ir_enable.
- ram_addr: combinational mux selected by addr_sel.
- data_out: combinational, equals the register selected by IR[6:5].
- Register write: on write_reg_enable, writes reg[dest] <= c_sel ? data_in : alu_result.
  - dest is IR[6:5] for LOAD, IR[3:2] for MOVE, IR[5:4] otherwise.
- Register reads are combinational. A read of the register being written in the same cycle returns the old value.
- ALU is combinational, 16-bit, and wraps.
  - unsigned_overflow = carry-out on ADD; borrow (A<B unsigned) on SUB.
  - signed_overflow = two's-complement overflow on ADD/SUB.
  - Both overflow flags are 0 for AND/OR.
  - zero = result==0; neg = result[15].
- Flags register: all four flags load together on flags_reg_enable and hold otherwise.
- Simultaneous strobes: pc_enable, ir_enable, write_reg_enable and flags_reg_enable are independent and may all assert in one cycle.
  - Each uses the pre-edge values of IR and the registers.

Optional Feature:
- Macro `K_AND_S_ILLEGAL_OP_EN`.
- Defined:
  - Adds output illegal_op (1 bit, sticky, reset 0).
  - illegal_op sets on the clock edge where ir_enable loads a word whose opcode is unlisted.
  - It clears only on reset.
  - Decode of that word is still I_NOP.
- Undefined: the port is absent, and unlisted opcodes silently decode to I_NOP.

Test Plan:
- Reset, then pulse ir_enable with data_in=0x8143 -> decoded_instruction=I_LOAD, ram_addr=0 (addr_sel=0).
  - Then set addr_sel=1 -> ram_addr=3.
  - Then write_reg_enable with c_sel=1 and data_in=0x1234 -> r2=0x1234.
- r0=0x7FFF, r1=0x0001, IR=0xA121, operation=00, write_reg_enable, flags_reg_enable -> r2=0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- r0=r1=0x0005, IR=0xA231, operation=01, flags_reg_enable -> r3=0, zero=1, unsigned_overflow=0.
  - Then with r1=6, r0-r1 -> 0xFFFF, unsigned_overflow=1, neg=1.
- PC=31, pc_enable with branch=0 -> PC=0.
  - IR=0x0114, pc_enable with branch=1 -> PC=0x14.
  - branch=1 with pc_enable=0 -> PC unchanged.
- STORE IR=0x8260 with r3=0xBEEF, addr_sel=1 -> data_out=0xBEEF, ram_addr=0.
  - Assert rst_n low mid-cycle -> PC, IR and registers are 0 immediately, decoded_instruction=I_NOP.
- With `K_AND_S_ILLEGAL_OP_EN`: ir_enable with data_in=0x7700 -> decoded_instruction=I_NOP, illegal_op=1 and it stays 1 through a following valid fetch.
